// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode, MEM/WB operand forwarding and load-use detection.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm16,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [3:0]        ex_aluctl,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_illegal,
    output logic              load_use_stall
);
    typedef struct packed {
        logic              valid;
        logic [3:0]        aluctl;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              branch;
        logic              illegal;
    } ex_t;

    ex_t ex_q, ex_d, cap;
    logic [3:0] r_ctl, ctl;
    logic r_ok, wr, mr, mw, br, ill, uimm, sext, dst_rd, uses_rt;
    logic [DATA_W-1:0] rt_fwd;

    always_comb begin
        r_ok = 1'b1;
        case (id_funct)
            6'h20: r_ctl = 4'b0010;
            6'h22: r_ctl = 4'b0110;
            6'h24: r_ctl = 4'b0000;
            6'h25: r_ctl = 4'b0001;
            6'h26: r_ctl = 4'b1111;
            6'h27: r_ctl = 4'b1100;
            6'h2A: r_ctl = 4'b0111;
            6'h18: r_ctl = 4'b1000;
            default: begin r_ctl = 4'b0000; r_ok = 1'b0; end
        endcase
    end

    always_comb begin
        {ctl, wr, mr, mw, br, ill, uimm, sext, dst_rd} = '0;
        case (id_opcode)
            6'h00: begin ctl = r_ctl; wr = r_ok; ill = !r_ok; dst_rd = 1'b1; end
            6'h08: begin ctl = 4'b0010; wr = 1'b1; uimm = 1'b1; sext = 1'b1; end
            6'h0C: begin ctl = 4'b0000; wr = 1'b1; uimm = 1'b1; end
            6'h0D: begin ctl = 4'b0001; wr = 1'b1; uimm = 1'b1; end
            6'h23: begin ctl = 4'b0010; wr = 1'b1; mr = 1'b1; uimm = 1'b1; sext = 1'b1; end
            6'h2B: begin ctl = 4'b0010; mw = 1'b1; uimm = 1'b1; sext = 1'b1; end
            6'h04: begin ctl = 4'b0110; br = 1'b1; end
            default: ill = 1'b1;
        endcase
    end

    assign uses_rt = id_opcode == 6'h00 || id_opcode == 6'h2B || id_opcode == 6'h04;

    // Control bits are qualified by id_valid at capture so an idle slot never carries stray writes.
    always_comb begin
        cap          = '0;
        cap.valid    = id_valid;
        cap.aluctl   = ctl;
        cap.rs       = id_rs;
        cap.rt       = id_rt;
        cap.dst      = dst_rd ? id_rd : id_rt;
        cap.rs_data  = id_rs_data;
        cap.rt_data  = id_rt_data;
        cap.imm      = sext ? {{(DATA_W-16){id_imm16[15]}}, id_imm16} : {{(DATA_W-16){1'b0}}, id_imm16};
        cap.use_imm  = uimm;
        cap.regwrite = id_valid && wr && cap.dst != '0;
        cap.memread  = id_valid && mr;
        cap.memwrite = id_valid && mw;
        cap.branch   = id_valid && br;
        cap.illegal  = id_valid && ill;
    end

    assign ex_d = flush ? '0 : stall_in ? ex_q : load_use_stall ? '0 : cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else ex_q <= ex_d;
    end

    function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] idx, input logic [DATA_W-1:0] rf);
        return (mem_regwrite && mem_dst != '0 && mem_dst == idx) ? mem_result :
               (wb_regwrite && wb_dst != '0 && wb_dst == idx) ? wb_result : rf;
    endfunction

    assign rt_fwd         = fwd(ex_q.rt, ex_q.rt_data);
    assign ex_in1         = fwd(ex_q.rs, ex_q.rs_data);
    assign ex_in2         = ex_q.use_imm ? ex_q.imm : rt_fwd;
    assign ex_store_data  = rt_fwd;
    assign ex_valid       = ex_q.valid;
    assign ex_aluctl      = ex_q.aluctl;
    assign ex_dst         = ex_q.dst;
    assign ex_regwrite    = ex_q.valid && ex_q.regwrite;
    assign ex_memread     = ex_q.valid && ex_q.memread;
    assign ex_memwrite    = ex_q.valid && ex_q.memwrite;
    assign ex_branch      = ex_q.valid && ex_q.branch;
    assign ex_illegal     = ex_q.valid && ex_q.illegal;
    assign load_use_stall = ex_q.valid && ex_q.memread && ex_q.dst != '0 && id_valid &&
                            (ex_q.dst == id_rs || (ex_q.dst == id_rt && uses_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm16;
    logic        stall_in, flush;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_dst, wb_dst;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal, load_use_stall;
    logic [3:0]  ex_aluctl;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [4:0]  ex_dst;

    typedef struct {
        string       tag;
        logic        v;
        logic [3:0]  ctl;
        logic [31:0] in1, in2, sd;
        logic [4:0]  dst;
        logic [4:0]  cb;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm16(id_imm16), .stall_in(stall_in), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_aluctl(ex_aluctl), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [15:0] imm);
        id_valid = v; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm;
    endtask

    task automatic push(input string tag, input logic v, input logic [3:0] ctl, input logic [31:0] in1,
                        input logic [31:0] in2, input logic [31:0] sd, input logic [4:0] dst, input logic [4:0] cb);
        exp_t e;
        e.tag = tag; e.v = v; e.ctl = ctl; e.in1 = in1; e.in2 = in2; e.sd = sd; e.dst = dst; e.cb = cb;
        sb.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        push(tag, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000);
    endtask

    task automatic cyc;
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_underflow observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".valid"}, 32'(ex_valid), 32'(e.v));
            chk({e.tag, ".aluctl"}, 32'(ex_aluctl), 32'(e.ctl));
            chk({e.tag, ".in1"}, ex_in1, e.in1);
            chk({e.tag, ".in2"}, ex_in2, e.in2);
            chk({e.tag, ".store"}, ex_store_data, e.sd);
            chk({e.tag, ".dst"}, 32'(ex_dst), 32'(e.dst));
            chk({e.tag, ".ctrl"}, 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal}), 32'(e.cb));
        end
    endtask

    logic [5:0] r_fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h18};
    logic [3:0] r_ctl [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b1100, 4'b0111, 4'b1000};

    initial begin
        rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
        mem_regwrite = 1'b0; mem_dst = '0; mem_result = '0;
        wb_regwrite = 1'b0; wb_dst = '0; wb_result = '0;
        set_id(0, 6'h0, 6'h0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(ex_valid), 0);
        chk("rst.aluctl", 32'(ex_aluctl), 0);
        chk("rst.ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal}), 0);
        rst_n = 1'b1;

        set_id(1, 6'h00, 6'h20, 1, 2, 3, 5, 7, 0);
        push("add", 1, 4'b0010, 5, 7, 7, 3, 5'b10000);
        cyc();
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(ex_valid), 0);
        chk("async_rst.regwrite", 32'(ex_regwrite), 0);
        chk("async_rst.aluctl", 32'(ex_aluctl), 0);
        chk("async_rst.in1", ex_in1, 0);
        set_id(0, 6'h0, 6'h0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        push_bubble("idle");
        cyc();

        set_id(1, 6'h08, 6'h00, 1, 4, 0, 10, 0, 16'hFFFF);
        push("addi", 1, 4'b0010, 10, 32'hFFFF_FFFF, 0, 4, 5'b10000);
        cyc();
        set_id(1, 6'h0D, 6'h00, 1, 5, 0, 10, 0, 16'h8000);
        push("ori", 1, 4'b0001, 10, 32'h0000_8000, 0, 5, 5'b10000);
        cyc();
        set_id(1, 6'h0C, 6'h00, 1, 5, 0, 10, 0, 16'h8001);
        push("andi", 1, 4'b0000, 10, 32'h0000_8001, 0, 5, 5'b10000);
        cyc();
        set_id(1, 6'h00, 6'h3F, 1, 2, 3, 5, 7, 0);
        push("bad_funct", 1, 4'b0000, 5, 7, 7, 3, 5'b00001);
        cyc();
        set_id(1, 6'h3F, 6'h20, 1, 2, 3, 5, 7, 0);
        push("bad_op", 1, 4'b0000, 5, 7, 7, 2, 5'b00001);
        cyc();
        set_id(1, 6'h2B, 6'h00, 2, 6, 0, 32'h40, 32'h55, 16'h0004);
        push("sw", 1, 4'b0010, 32'h40, 4, 32'h55, 6, 5'b00100);
        cyc();
        set_id(1, 6'h04, 6'h00, 1, 2, 0, 5, 9, 16'h0003);
        push("beq", 1, 4'b0110, 5, 9, 9, 2, 5'b00010);
        cyc();
        for (int i = 0; i < 8; i++) begin
            set_id(1, 6'h00, r_fn[i], 1, 2, 3, 5, 7, 0);
            push($sformatf("rtype%0d", i), 1, r_ctl[i], 5, 7, 7, 3, 5'b10000);
            cyc();
        end

        set_id(1, 6'h23, 6'h00, 1, 8, 0, 32'h100, 0, 16'h0004);
        push("lw_a", 1, 4'b0010, 32'h100, 4, 0, 8, 5'b11000);
        cyc();
        set_id(1, 6'h00, 6'h20, 8, 1, 9, 3, 4, 0);
        #1 chk("lus_rs", 32'(load_use_stall), 1);
        push_bubble("lus_bubble");
        cyc();
        chk("lus_drop", 32'(load_use_stall), 0);
        push("add_after_lw", 1, 4'b0010, 3, 4, 4, 9, 5'b10000);
        cyc();
        set_id(1, 6'h23, 6'h00, 1, 8, 0, 32'h100, 0, 16'h0004);
        push("lw_b", 1, 4'b0010, 32'h100, 4, 0, 8, 5'b11000);
        cyc();
        set_id(1, 6'h0D, 6'h00, 1, 8, 0, 10, 0, 16'h0001);
        #1 chk("lus_ori_rt", 32'(load_use_stall), 0);
        push("ori_after_lw", 1, 4'b0001, 10, 1, 0, 8, 5'b10000);
        cyc();
        set_id(1, 6'h23, 6'h00, 1, 8, 0, 32'h100, 0, 16'h0004);
        push("lw_c", 1, 4'b0010, 32'h100, 4, 0, 8, 5'b11000);
        cyc();
        set_id(1, 6'h2B, 6'h00, 1, 8, 0, 32'h40, 32'h55, 16'h0004);
        #1 chk("lus_sw_rt", 32'(load_use_stall), 1);
        push_bubble("lus_sw_bubble");
        cyc();
        push("sw_after_lw", 1, 4'b0010, 32'h40, 4, 32'h55, 8, 5'b00100);
        cyc();

        set_id(1, 6'h00, 6'h20, 1, 2, 3, 5, 7, 0);
        push("pre_stall", 1, 4'b0010, 5, 7, 7, 3, 5'b10000);
        cyc();
        stall_in = 1'b1;
        set_id(1, 6'h00, 6'h22, 4, 6, 10, 11, 12, 0);
        for (int i = 0; i < 3; i++) begin
            push($sformatf("stall%0d", i), 1, 4'b0010, 5, 7, 7, 3, 5'b10000);
            cyc();
        end
        flush = 1'b1;
        push_bubble("flush_stall");
        cyc();
        flush = 1'b0;
        stall_in = 1'b0;

        set_id(1, 6'h00, 6'h22, 5, 6, 7, 1, 2, 0);
        push("sub_fwd", 1, 4'b0110, 1, 2, 2, 7, 5'b10000);
        cyc();
        mem_regwrite = 1'b1; mem_dst = 5; mem_result = 32'h10;
        wb_regwrite = 1'b1; wb_dst = 5; wb_result = 32'h20;
        #1 chk("fwd_mem_pri", ex_in1, 32'h10);
        mem_regwrite = 1'b0;
        #1 chk("fwd_wb", ex_in1, 32'h20);
        wb_dst = 6;
        #1 chk("fwd_wb_rt.in2", ex_in2, 32'h20);
        chk("fwd_wb_rt.store", ex_store_data, 32'h20);
        chk("fwd_wb_rt.in1", ex_in1, 1);
        mem_regwrite = 1'b1; mem_dst = 0; wb_dst = 0;
        #1 chk("fwd_dst0.in1", ex_in1, 1);
        chk("fwd_dst0.in2", ex_in2, 2);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

        set_id(1, 6'h00, 6'h20, 1, 2, 0, 5, 7, 0);
        push("add_r0", 1, 4'b0010, 5, 7, 7, 0, 5'b00000);
        cyc();
        set_id(1, 6'h00, 6'h20, 0, 2, 3, 32'h77, 7, 0);
        push("add_rs0", 1, 4'b0010, 32'h77, 7, 7, 3, 5'b10000);
        cyc();
        mem_regwrite = 1'b1; mem_dst = 0; mem_result = 32'hDEAD;
        wb_regwrite = 1'b1; wb_dst = 0; wb_result = 32'hBEEF;
        #1 chk("no_fwd_r0", ex_in1, 32'h77);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and ALU-operand stage of the pipelined MIPS core; sits directly upstream of the ALU.
- Registers decoded instruction fields from ID and generates the 4-bit ALU control code.
- Forwards results from MEM and WB into the ALU operands, detects load-use hazards, and supports downstream stall and flush.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  instruction[31:26]
- id_funct  in  6  instruction[5:0]
- id_rs, id_rt, id_rd  in  REG_AW  register indices
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm16  in  16  instruction[15:0]
- stall_in  in  1  downstream busy; hold stage
- flush  in  1  kill the instruction entering EX (branch taken)
- mem_regwrite  in  1  MEM-stage write enable
- mem_dst  in  REG_AW  MEM-stage destination
- mem_result  in  DATA_W  MEM-stage result
- wb_regwrite  in  1  WB-stage write enable
- wb_dst  in  REG_AW  WB-stage destination
- wb_result  in  DATA_W  WB-stage result
- ex_valid  out  1  EX holds a real instruction
- ex_aluctl  out  4  ALU control code
- ex_in1, ex_in2  out  DATA_W  ALU operands after forwarding and immediate selection
- ex_store_data  out  DATA_W  forwarded rt value for sw
- ex_dst  out  REG_AW  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1  control bits (all gated by ex_valid)
- ex_illegal  out  1  unsupported opcode/funct registered
- load_use_stall  out  1  combinational; freeze PC and IF/ID

Behaviour:
- Reset, asynchronous on rst_n low: all registered fields = 0, so ex_valid=0, ex_aluctl=4'b0000, ex_regwrite/ex_memread/ex_memwrite/ex_branch/ex_illegal=0.
  - ex_in1, ex_in2 and ex_store_data then reflect zeroed registers plus forwarding.
  - Reset mid-stall or mid-flush discards everything.
- Register update priority, per rising edge:
  1. flush → load bubble (all fields 0).
  2. Else stall_in → hold all fields.
  3. Else load_use_stall → load bubble.
  4. Else capture ID fields with ex_valid=id_valid.
- Latency: 1 cycle from ID to EX outputs.
- Decode, R-type (opcode 0x00), funct → ALU code:
  - 0x20 add → 0010
  - 0x22 sub → 0110
  - 0x24 and → 0000
  - 0x25 or → 0001
  - 0x26 xor → 1111
  - 0x27 nor → 1100
  - 0x2A slt → 0111
  - 0x18 mult → 1000
  - All R-type: dst=rd, regwrite=1.
- Decode, I-type, opcode → ALU code, immediate, control:
  - addi 0x08 → 0010, sign-extended imm, regwrite
  - andi 0x0C → 0000, zero-extended imm, regwrite
  - ori 0x0D → 0001, zero-extended imm, regwrite
  - lw 0x23 → 0010, sign-extended imm, regwrite+memread
  - sw 0x2B → 0010, sign-extended imm, memwrite
  - beq 0x04 → 0110, rt operand, branch
  - I-type dst=rt.
- Any other opcode/funct: ex_illegal=1, all control 0, aluctl 0000.
- A destination of register 0 forces regwrite=0.
- Immediate select: ex_in2 = extended imm for addi/andi/ori/lw/sw; otherwise forwarded rt.
- Forwarding, combinational on registered rs/rt:
  - Source = mem_result if mem_regwrite && mem_dst!=0 && mem_dst==idx.
  - Else wb_result if wb_regwrite && wb_dst!=0 && wb_dst==idx.
  - Else the registered register-file data.
  - MEM has priority over WB.
  - Index 0 is never forwarded.
- load_use_stall = ex_valid && ex_memread && ex_dst!=0 && id_valid && (ex_dst==id_rs || (ex_dst==id_rt && ID uses rt)).
  - ID uses rt for R-type, sw and beq.
  - It stays asserted while stall_in holds the stage.
- flush and stall_in together: flush wins.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a valid instruction in EX → all outputs and control bits 0 immediately; after release with id_valid=0, ex_valid stays 0.
- Decode: add $3,$1,$2 with rs_data=5, rt_data=7, no forwarding → next cycle ex_aluctl=0010, ex_in1=5, ex_in2=7, ex_dst=3, ex_regwrite=1. addi $4,$1,-1 → ex_in2=0xFFFFFFFF. ori with imm 0x8000 → ex_in2=0x00008000. Funct 0x3F → ex_illegal=1, regwrite=0.
- Forwarding: EX holds sub rs=$5; mem_dst=5 with mem_result=0x10, and wb_dst=5 with wb_result=0x20 → ex_in1=0x10. mem_dst=0 with wb_dst=0 → register-file value used.
- Load-use: EX holds lw $8 while ID holds add $9,$8,$1 → load_use_stall=1; next cycle ex_valid=0 (bubble), stall drops, add captured the cycle after.
- Stall and flush: stall_in=1 for 3 cycles → EX outputs constant. flush=1 with stall_in=1 → next cycle ex_valid=0, ex_regwrite=0.
- Register zero: add $0,$1,$2 → ex_regwrite=0. mem_dst=0 with mem_regwrite=1 → no forward to rs=$0.
